coeff_loader: RTL
=================

Name: coeff_loader

Overview:
- Writer side of the 71-entry FIR coefficient register array.
- Accepts a valid/ready byte stream of signed 8-bit taps followed by one checksum byte.
- Drives the array's addr/coefficient/write_en write port sequentially from address 0, then validates the checksum and reports done/error to the modulator control logic.

Parameters:
- NUM_TAPS, 71, number of coefficients per load; addresses 0..NUM_TAPS-1.
- ADDR_W, 7, width of the addr output.
- DATA_W, 8, coefficient and stream width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load.
- abort  input  1  cancel an in-progress load.
- s_data  input  DATA_W  signed stream byte: coefficient or trailing checksum.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts s_data this cycle.
- addr  output  ADDR_W  array write address.
- coefficient  output  DATA_W  signed array write data.
- write_en  output  1  array write strobe, one cycle per coefficient.
- busy  output  1  load in progress.
- done  output  1  load completed; held until next start.
- csum_err  output  1  checksum mismatch on the last load; held until next start.

Behaviour:
- Reset (async assert, sync release): state IDLE; addr=0, coefficient=0, write_en=0, busy=0, done=0, csum_err=0; tap counter and checksum accumulator cleared.
- s_ready is combinational: 1 in LOAD or CHECK and abort=0, else 0. A beat transfers when s_valid & s_ready.
- IDLE:
  - start=1 -> LOAD; clear counter, accumulator, done and csum_err; busy=1 from the next cycle.
- LOAD:
  - Each transfer registers addr=counter, coefficient=s_data, write_en=1 on the following cycle.
  - write_en is 0 in any cycle not following a transfer, so latency is exactly 1 cycle and there is one strobe per beat.
  - accumulator += s_data, mod 2^DATA_W. Counter increments.
  - The transfer with counter=NUM_TAPS-1 -> CHECK. addr never exceeds NUM_TAPS-1.
  - Gaps (s_valid=0) hold all state; write_en=0 during gaps.
- CHECK:
  - One transfer is taken as the checksum byte and is not written to the array.
  - Pass condition: (accumulator + s_data) mod 256 = 0.
  - csum_err = NOT pass; then -> DONE.
- DONE:
  - done=1, busy=0; -> IDLE the same cycle, so done and csum_err remain as levels until the next start.
- abort=1 in LOAD or CHECK:
  - -> IDLE next cycle; busy=0, done=0, csum_err=0.
  - A beat presented in the same cycle is not accepted (s_ready=0) and not written.
  - Array entries already written are left as is; the loader does not roll them back.
- abort in IDLE/DONE: no effect.
- start while busy=1: ignored. start and abort in the same cycle in IDLE: start wins.
- The loader never reads the array. addr and coefficient hold their last written values between strobes.
- Reset mid-load: all outputs return to reset values asynchronously; any strobe pending for the next cycle is lost.

Test Plan:
- Full load, no backpressure: start, then 71 beats with s_data=k-35 (k=0..70), then checksum 0x00 -> 71 write_en pulses with addr 0..70 and coefficient -35..35, each one cycle after its beat; done=1, csum_err=0, busy=0.
- Checksum error: same stream with checksum 0x01 -> all 71 writes occur; done=1, csum_err=1.
- Gapped stream: s_valid toggled with a random duty on the same 72 beats -> identical addr/coefficient write sequence; no write_en while s_valid=0; final addr=70.
- Abort at tap 20: abort asserted in the cycle a beat for addr 20 is presented -> writes for addr 0..19 only; no write_en for addr 20; busy=0, done=0 next cycle. A new start then reloads from addr 0.
- Start while busy: start pulsed at tap 10 -> counter not reset; writes continue at addr 10..70; one done at the end.
- Async reset at tap 30: rst_n low mid-cycle -> write_en, busy, done, csum_err, addr immediately 0. After release, start restarts at addr 0.

Source files
------------

// File: rtl/coeff_loader.sv
// Streams signed taps into the FIR coefficient array, one write strobe per beat,
// then checks a trailing checksum byte and reports done/csum_err as held levels.
module coeff_loader #(
  parameter int unsigned NUM_TAPS = 71,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] coefficient,
  output logic              write_en,
  output logic              busy,
  output logic              done,
  output logic              csum_err
);

  // The completion step is folded into the checksum transfer: done is registered
  // and the FSM returns straight to idle, so done/csum_err stay as levels.
  typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;

  localparam logic [ADDR_W-1:0] LastTap = ADDR_W'(NUM_TAPS - 1);

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_cnt, w_cnt_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [DATA_W-1:0] r_acc, w_acc_d;
  logic [DATA_W-1:0] r_coef, w_coef_d;
  logic [DATA_W-1:0] w_csum;
  logic              r_we, w_we_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_err, w_err_d;
  logic              w_xfer;

  assign s_ready = ((r_state == StLoad) || (r_state == StCheck)) && !abort;
  assign w_xfer  = s_valid && s_ready;
  assign w_csum  = r_acc + s_data;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_addr_d  = r_addr;
    w_acc_d   = r_acc;
    w_coef_d  = r_coef;
    w_we_d    = 1'b0;
    w_busy_d  = r_busy;
    w_done_d  = r_done;
    w_err_d   = r_err;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StLoad;
          w_cnt_d   = '0;
          w_acc_d   = '0;
          w_done_d  = 1'b0;
          w_err_d   = 1'b0;
          w_busy_d  = 1'b1;
        end
      end
      StLoad: begin
        if (abort) begin
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b0;
          w_err_d   = 1'b0;
        end else if (w_xfer) begin
          w_we_d   = 1'b1;
          w_addr_d = r_cnt;
          w_coef_d = s_data;
          w_acc_d  = w_csum;
          w_cnt_d  = r_cnt + 1'b1;
          if (r_cnt == LastTap) begin
            w_state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (abort) begin
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b0;
          w_err_d   = 1'b0;
        end else if (w_xfer) begin
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b1;
          w_err_d   = (w_csum != '0);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_acc   <= '0;
      r_coef  <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_addr  <= w_addr_d;
      r_acc   <= w_acc_d;
      r_coef  <= w_coef_d;
      r_we    <= w_we_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
    end
  end

  assign addr        = r_addr;
  assign coefficient = r_coef;
  assign write_en    = r_we;
  assign busy        = r_busy;
  assign done        = r_done;
  assign csum_err    = r_err;

endmodule
